cory_rom_streamer: RTL and testbench

Read sequencer for the single-port ROM (`clk`/`csn`/`addr`/`rdata`, one-cycle registered read). It accepts a command of start address and word count on a valid/ready port. It then drives `csn`/`addr` to fetch consecutive words and delivers them as a valid/ready stream with a `last` marker. A 2-entry output buffer absorbs the ROM's fixed latency, so backpressure never drops or duplicates a word and sustained throughput is one word per cycle.

---
 rtl/cory_rom_stream_pkg.sv | 15 +
 rtl/cory_rom_skid2.sv | 64 ++++++
 rtl/cory_rom_streamer.sv | 120 ++++++++++++
 tb/tb_cory_rom_streamer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cory_rom_stream_pkg.sv
// Shared definitions for the ROM read streamer: FSM encoding and
// output buffer depth.
package cory_rom_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Two entries cover the single read in flight plus the word held at
    // the output, so a stalled consumer never loses a returning word.
    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/cory_rom_skid2.sv
// Two-entry FIFO of {last, data}. Entry 0 is the head and drives the
// stream outputs directly. Push and pop may coincide at any occupancy;
// the caller never pops when empty and never pushes when full.
module cory_rom_skid2
    import cory_rom_stream_pkg::*;
#(
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [D-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [D-1:0] head_data,
    output logic         head_last,
    output logic [1:0]   count
);

    logic [D-1:0] tail_data;
    logic         tail_last;

    // Shift-register FIFO: head refills from the tail on pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
            count     <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else if (count != 2'(BUF_DEPTH)) begin
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= push_data;
                        tail_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cory_rom_streamer.sv
// Read sequencer for a single-port ROM with a one-cycle registered read.
// Accepts {addr, len} commands and streams the words out with a last
// marker, buffering two words so backpressure costs no data.
module cory_rom_streamer
    import cory_rom_stream_pkg::*;
#(
    parameter int A = 8,
    parameter int D = 8,
    parameter int L = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_cmd_valid,
    input  logic [A-1:0] i_cmd_addr,
    input  logic [L-1:0] i_cmd_len,
    output logic         i_cmd_ready,
    output logic         o_rom_csn,
    output logic [A-1:0] o_rom_addr,
    input  logic [D-1:0] i_rom_rdata,
    output logic         o_dat_valid,
    output logic [D-1:0] o_dat_data,
    output logic         o_dat_last,
    input  logic         i_dat_ready,
    output logic         o_busy
);

    localparam int SIZE = 2 ** A;
    localparam logic [A-1:0] ADDR_LAST = A'(SIZE - 1);

    state_t       state;
    logic         cmd_ready;
    logic [A-1:0] next_addr;
    logic [A-1:0] last_addr;
    logic [L-1:0] remaining;
    logic         inflight;
    logic         inflight_last;
    logic [1:0]   buf_count;
    logic         pop;
    logic         issue;
    logic         issue_last;
    logic [2:0]   occ;

    // occ is the buffer occupancy after this cycle's pop, counting the
    // word already on its way back from the ROM.
    assign pop        = o_dat_valid & i_dat_ready;
    assign occ        = 3'(buf_count) + 3'(inflight) - 3'(pop);
    assign issue      = (state == ST_RUN) && (remaining != '0) && (occ < 3'(BUF_DEPTH));
    assign issue_last = issue && (remaining == L'(1));

    // Address is shown only while reading; otherwise the last issued
    // address is held so the ROM pins stay quiet.
    assign o_rom_csn   = ~issue;
    assign o_rom_addr  = issue ? next_addr : last_addr;
    assign o_dat_valid = (buf_count != 2'd0);
    assign i_cmd_ready = cmd_ready;
    assign o_busy      = (state != ST_IDLE);

    // Command FSM with address/remaining counters and read-in-flight flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b0;
            next_addr     <= '0;
            last_addr     <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue_last;
            if (issue) begin
                last_addr <= next_addr;
                next_addr <= (next_addr == ADDR_LAST) ? '0 : next_addr + A'(1);
                remaining <= remaining - L'(1);
            end
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (i_cmd_valid && cmd_ready) begin
                        next_addr <= i_cmd_addr;
                        remaining <= i_cmd_len;
                        if (i_cmd_len != '0) begin
                            state     <= ST_RUN;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Leave once the final word is popped this cycle.
                    if (occ == 3'd0) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    cory_rom_skid2 #(.D(D)) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (i_rom_rdata),
        .push_last (inflight_last),
        .pop       (pop),
        .head_data (o_dat_data),
        .head_last (o_dat_last),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_cory_rom_streamer.sv
// Directed bench for cory_rom_streamer against a mem[i]=i ROM model.
module tb_cory_rom_streamer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_cmd_valid;
    logic [7:0] i_cmd_addr;
    logic [7:0] i_cmd_len;
    logic       i_cmd_ready;
    logic       o_rom_csn;
    logic [7:0] o_rom_addr;
    logic [7:0] i_rom_rdata;
    logic       o_dat_valid;
    logic [7:0] o_dat_data;
    logic       o_dat_last;
    logic       i_dat_ready;
    logic       o_busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] rom [256];
    logic [8:0] pop_q [$];
    logic [7:0] iss_q [$];
    int         outstanding;
    logic       stall_prev;
    logic [7:0] prev_data;
    logic       prev_last;

    always #5 clk = ~clk;

    cory_rom_streamer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_len   (i_cmd_len),
        .i_cmd_ready (i_cmd_ready),
        .o_rom_csn   (o_rom_csn),
        .o_rom_addr  (o_rom_addr),
        .i_rom_rdata (i_rom_rdata),
        .o_dat_valid (o_dat_valid),
        .o_dat_data  (o_dat_data),
        .o_dat_last  (o_dat_last),
        .i_dat_ready (i_dat_ready),
        .o_busy      (o_busy)
    );

    // ROM model: registered read, one cycle after csn low.
    always @(posedge clk) begin
        if (!o_rom_csn) i_rom_rdata <= rom[o_rom_addr];
    end

    // Stream monitor: records pops and issues, checks outstanding reads,
    // known ROM addresses and output stability under backpressure.
    always @(negedge clk) begin
        if (!reset_n) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                n_assert++;
                assert ({o_dat_valid, o_dat_last, o_dat_data} === {1'b1, prev_last, prev_data})
                else begin
                    n_fail++;
                    $error("FAIL stall_hold: observed %0h expected %0h",
                           {o_dat_valid, o_dat_last, o_dat_data}, {1'b1, prev_last, prev_data});
                end
            end
            if (!o_rom_csn) begin
                n_assert++;
                assert (!$isunknown(o_rom_addr)) else begin
                    n_fail++;
                    $error("FAIL rom_addr_known: observed %0h expected known", o_rom_addr);
                end
                iss_q.push_back(o_rom_addr);
                outstanding++;
            end
            if (o_dat_valid && i_dat_ready) begin
                pop_q.push_back({o_dat_last, o_dat_data});
                outstanding--;
            end
            n_assert++;
            assert (outstanding >= 0 && outstanding <= 2) else begin
                n_fail++;
                $error("FAIL outstanding: observed %0d expected 0..2", outstanding);
            end
            stall_prev = o_dat_valid && !i_dat_ready;
            prev_data  = o_dat_data;
            prev_last  = o_dat_last;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_cmd_ready"}, i_cmd_ready, 0);
        chk({pfx, "_csn"},       o_rom_csn,   1);
        chk({pfx, "_addr"},      o_rom_addr,  0);
        chk({pfx, "_valid"},     o_dat_valid, 0);
        chk({pfx, "_data"},      o_dat_data,  0);
        chk({pfx, "_last"},      o_dat_last,  0);
        chk({pfx, "_busy"},      o_busy,      0);
    endtask

    task automatic wait_idle(input string tag);
        i_dat_ready = 1'b1;
        for (int i = 0; i < 100 && !i_cmd_ready; i++) begin
            next_cycle();
            sample();
        end
        chk(tag, i_cmd_ready, 1);
    endtask

    // Issue one command in the current cycle, then drop valid next cycle.
    task automatic send_cmd(input logic [7:0] addr, input logic [7:0] len);
        next_cycle();
        i_cmd_valid = 1'b1;
        i_cmd_addr  = addr;
        i_cmd_len   = len;
        sample();
        next_cycle();
        i_cmd_valid = 1'b0;
        sample();
    endtask

    logic [7:0] t1_csn   [7] = '{0, 0, 0, 0, 1, 1, 1};
    logic [7:0] t1_addr  [7] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h13, 8'h13, 8'h13};
    logic [7:0] t1_valid [7] = '{0, 0, 1, 1, 1, 1, 0};
    logic [7:0] t1_data  [7] = '{0, 0, 8'h10, 8'h11, 8'h12, 8'h13, 0};
    logic [7:0] t1_last  [7] = '{0, 0, 0, 0, 0, 1, 0};
    logic [7:0] t1_rdy   [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [7:0] wr_exp   [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [8:0] b2b_exp  [5] = '{9'h020, 9'h021, 9'h122, 9'h030, 9'h131};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_iss;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i);
        void'($urandom(32'h00C0FFEE));
        reset_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_len   = '0;
        i_dat_ready = 1'b1;

        // Reset values, and ready only rises on the first edge after release
        #3;
        chk_reset_vals("rst0");
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        sample();
        chk("rel_cmd_ready_low", i_cmd_ready, 0);
        wait_idle("rel_idle");

        // Basic command: exact cycle-by-cycle timing from handshake T
        next_cycle();
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 8'h10;
        i_cmd_len   = 8'd4;
        sample();
        chk("t1_ready_T", i_cmd_ready, 1);
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            if (k == 0) i_cmd_valid = 1'b0;
            sample();
            chk($sformatf("t1_csn_T%0d", k + 1), o_rom_csn, 32'(t1_csn[k]));
            chk($sformatf("t1_addr_T%0d", k + 1), o_rom_addr, 32'(t1_addr[k]));
            chk($sformatf("t1_valid_T%0d", k + 1), o_dat_valid, 32'(t1_valid[k]));
            if (t1_valid[k] != 0) begin
                chk($sformatf("t1_data_T%0d", k + 1), o_dat_data, 32'(t1_data[k]));
                chk($sformatf("t1_last_T%0d", k + 1), o_dat_last, 32'(t1_last[k]));
            end
            chk($sformatf("t1_cmd_ready_T%0d", k + 1), i_cmd_ready, 32'(t1_rdy[k]));
            chk($sformatf("t1_busy_T%0d", k + 1), o_busy, 32'(t1_rdy[k] == 0));
        end

        // Address wrap at the top of the ROM
        pop_q.delete();
        iss_q.delete();
        send_cmd(8'hFE, 8'd4);
        wait_idle("wr_idle");
        chk("wr_issue_count", iss_q.size(), 4);
        chk("wr_word_count", pop_q.size(), 4);
        for (int k = 0; k < 4 && k < iss_q.size(); k++)
            chk($sformatf("wr_addr_%0d", k), iss_q[k], 32'(wr_exp[k]));
        for (int k = 0; k < 4 && k < pop_q.size(); k++)
            chk($sformatf("wr_word_%0d", k), pop_q[k], {23'd0, k == 3, wr_exp[k]});

        // Backpressure: held off 5 cycles, then seeded random ready
        pop_q.delete();
        next_cycle();
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 8'h00;
        i_cmd_len   = 8'd8;
        i_dat_ready = 1'b0;
        sample();
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            if (k == 1) i_cmd_valid = 1'b0;
            sample();
        end
        chk("bp_stall_csn", o_rom_csn, 1);
        chk("bp_stall_valid", o_dat_valid, 1);
        chk("bp_stall_data", o_dat_data, 8'h00);
        for (int i = 0; i < 400 && pop_q.size() < 8; i++) begin
            next_cycle();
            i_dat_ready = 1'($urandom_range(0, 1));
            sample();
        end
        wait_idle("bp_idle");
        chk("bp_word_count", pop_q.size(), 8);
        for (int k = 0; k < 8 && k < pop_q.size(); k++)
            chk($sformatf("bp_word_%0d", k), pop_q[k], {23'd0, k == 7, 8'(k)});

        // Null command: nothing issued, still ready next cycle
        pop_q.delete();
        n_iss = iss_q.size();
        next_cycle();
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 8'h55;
        i_cmd_len   = 8'd0;
        sample();
        chk("null_ready_T", i_cmd_ready, 1);
        next_cycle();
        i_cmd_valid = 1'b0;
        sample();
        chk("null_csn", o_rom_csn, 1);
        chk("null_valid", o_dat_valid, 0);
        chk("null_cmd_ready", i_cmd_ready, 1);
        chk("null_busy", o_busy, 0);
        next_cycle();
        sample();
        chk("null_no_issue", iss_q.size(), n_iss);
        chk("null_no_word", pop_q.size(), 0);

        // Reset in the middle of a long command
        pop_q.delete();
        send_cmd(8'h00, 8'd16);
        for (int i = 0; i < 60 && pop_q.size() < 5; i++) begin
            next_cycle();
            sample();
        end
        chk("rst_mid_words_seen", pop_q.size() >= 5, 1);
        next_cycle();
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        sample();
        next_cycle();
        reset_n = 1'b1;
        sample();
        chk_reset_vals("rst_rel");
        wait_idle("rst_idle");
        pop_q.delete();
        send_cmd(8'h40, 8'd2);
        wait_idle("rst_cmd_idle");
        chk("rst_cmd_count", pop_q.size(), 2);
        if (pop_q.size() == 2) begin
            chk("rst_cmd_w0", pop_q[0], 9'h040);
            chk("rst_cmd_w1", pop_q[1], 9'h141);
        end

        // Back-to-back: second command held valid while the first runs
        pop_q.delete();
        next_cycle();
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 8'h20;
        i_cmd_len   = 8'd3;
        sample();
        chk("b2b_ready_T", i_cmd_ready, 1);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 1) begin
                i_cmd_addr = 8'h30;
                i_cmd_len  = 8'd2;
            end
            sample();
            chk($sformatf("b2b_ready_T%0d", k), i_cmd_ready, 32'(k == 6));
        end
        next_cycle();
        i_cmd_valid = 1'b0;
        sample();
        chk("b2b_second_csn", o_rom_csn, 0);
        chk("b2b_second_addr", o_rom_addr, 8'h30);
        wait_idle("b2b_idle");
        chk("b2b_word_count", pop_q.size(), 5);
        for (int k = 0; k < 5 && k < pop_q.size(); k++)
            chk($sformatf("b2b_word_%0d", k), pop_q[k], 32'(b2b_exp[k]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
